// File: rtl/mole_judge.sv
// rtl/mole_judge.sv - whack-a-mole judge: mole selection and timing, hit/miss scoring, BCD counts
// Optional feature macro: MOLE_SW_SYNC_EN (adds a synchronizer flop ahead of the switch sample)
module mole_judge #(
  parameter int TICK_SLOW = 100_000_000,
  parameter int TICK_FAST = 50_000_000,
  parameter int GAP_TICKS = 25_000_000,
  parameter int MAX_MISS  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       lev,
  input  logic [7:0] sw,
  output logic [7:0] led,
  output logic [7:0] score_bcd,
  output logic [7:0] miss_bcd,
  output logic       hit_p,
  output logic       miss_p,
  output logic       game_over
);

  typedef enum logic [1:0] {ST_GAP, ST_SHOW, ST_OVER} state_t;

  // Timers count down to zero, so every load is the duration minus one.
  localparam logic [31:0] GAP_LOAD  = 32'(GAP_TICKS - 1);
  localparam logic [31:0] SLOW_LOAD = 32'(TICK_SLOW - 1);
  localparam logic [31:0] FAST_LOAD = 32'(TICK_FAST - 1);
  localparam logic [7:0]  MISS_END  = {4'(MAX_MISS / 10), 4'(MAX_MISS % 10)};

  state_t      r_state;
  logic [31:0] r_timer;
  logic [15:0] r_lfsr;
  logic [2:0]  r_prev;
  logic [7:0]  r_led;
  logic [7:0]  r_score;
  logic [7:0]  r_miss;
  logic        r_hit_p;
  logic        r_miss_p;
  logic        r_over;
  logic [7:0]  r_s;
  logic [7:0]  r_s_prev;

  state_t      w_state_n;
  logic [31:0] w_timer_n;
  logic [2:0]  w_prev_n;
  logic [7:0]  w_led_n;
  logic [7:0]  w_score_n;
  logic [7:0]  w_miss_n;
  logic        w_hit_n;
  logic        w_miss_p_n;
  logic        w_over_n;

  logic [7:0]  w_press;
  logic        w_wrong;
  logic        w_hit;
  logic        w_lfsr_fb;
  logic [2:0]  w_cand;
  logic [2:0]  w_idx;
  logic [7:0]  w_miss_inc;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

`ifdef MOLE_SW_SYNC_EN
  logic [7:0] r_sw_meta;

  // Two-flop synchronizer; r_s is the second stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_meta <= '0;
      r_s       <= '0;
    end else begin
      r_sw_meta <= sw;
      r_s       <= r_sw_meta;
    end
  end
`else
  // Single sample register for the switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_s <= '0;
    else     r_s <= sw;
  end
`endif

  // Previous sample keeps updating during pause so held switches never count later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_s_prev <= '0;
    else     r_s_prev <= r_s;
  end

  // Free-running LFSR (taps 16,14,13,11), advances even while paused.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  assign w_press    = r_s & ~r_s_prev;
  assign w_wrong    = |(w_press & ~r_led);
  assign w_hit      = (|w_press) && !w_wrong;
  assign w_cand     = r_lfsr[2:0];
  assign w_idx      = (w_cand == r_prev) ? w_cand + 3'd1 : w_cand;
  assign w_miss_inc = bcd_inc(r_miss);

  // Next-state and next-output decisions; nothing moves while paused.
  always_comb begin
    w_state_n  = r_state;
    w_timer_n  = r_timer;
    w_prev_n   = r_prev;
    w_led_n    = r_led;
    w_score_n  = r_score;
    w_miss_n   = r_miss;
    w_hit_n    = 1'b0;
    w_miss_p_n = 1'b0;
    w_over_n   = r_over;
    if (!pause) begin
      case (r_state)
        ST_GAP: begin
          if (r_timer == 32'd0) begin
            w_state_n = ST_SHOW;
            w_led_n   = 8'd1 << w_idx;
            w_prev_n  = w_idx;
            w_timer_n = lev ? FAST_LOAD : SLOW_LOAD;
          end else begin
            w_timer_n = r_timer - 32'd1;
          end
        end
        ST_SHOW: begin
          if (w_hit) begin
            if (r_score != 8'h99) w_score_n = bcd_inc(r_score);
            w_hit_n   = 1'b1;
            w_state_n = ST_GAP;
            w_led_n   = 8'h00;
            w_timer_n = GAP_LOAD;
          end else if (w_wrong || (r_timer == 32'd0)) begin
            w_miss_n   = w_miss_inc;
            w_miss_p_n = 1'b1;
            if (w_miss_inc == MISS_END) begin
              w_state_n = ST_OVER;
              w_led_n   = 8'hFF;
              w_over_n  = 1'b1;
            end else begin
              w_state_n = ST_GAP;
              w_led_n   = 8'h00;
              w_timer_n = GAP_LOAD;
            end
          end else begin
            w_timer_n = r_timer - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Game state, timer, counts and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_GAP;
      r_timer  <= GAP_LOAD;
      r_prev   <= 3'd0;
      r_led    <= 8'h00;
      r_score  <= 8'h00;
      r_miss   <= 8'h00;
      r_hit_p  <= 1'b0;
      r_miss_p <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_timer  <= w_timer_n;
      r_prev   <= w_prev_n;
      r_led    <= w_led_n;
      r_score  <= w_score_n;
      r_miss   <= w_miss_n;
      r_hit_p  <= w_hit_n;
      r_miss_p <= w_miss_p_n;
      r_over   <= w_over_n;
    end
  end

  assign led       = r_led;
  assign score_bcd = r_score;
  assign miss_bcd  = r_miss;
  assign hit_p     = r_hit_p;
  assign miss_p    = r_miss_p;
  assign game_over = r_over;

endmodule

// File: tb/tb_mole_judge.sv
// tb/tb_mole_judge.sv - self-checking bench for mole_judge: directed sequences, vector table, random lockstep model
module tb_mole_judge;

  localparam int TS = 20;
  localparam int TF = 10;
  localparam int GT = 4;
  localparam int MM = 3;
`ifdef MOLE_SW_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic       lev = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [7:0] led, score_bcd, miss_bcd;
  logic       hit_p, miss_p, game_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mole_judge #(
    .TICK_SLOW(TS), .TICK_FAST(TF), .GAP_TICKS(GT), .MAX_MISS(MM)
  ) dut (
    .clk(clk), .rst(rst), .pause(pause), .lev(lev), .sw(sw),
    .led(led), .score_bcd(score_bcd), .miss_bcd(miss_bcd),
    .hit_p(hit_p), .miss_p(miss_p), .game_over(game_over)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[16-1] ^ l[14-1] ^ l[13-1] ^ l[11-1]};
  endfunction

  function automatic int pick_idx(input logic [15:0] l, input int prev);
    int c;
    c = int'(l[2:0]);
    if (c == prev) c = (c + 1) % 8;
    return c;
  endfunction

  // Reference model: game phase plus "cycles left" counters and integer tallies.
  int         m_phase;   // 0 dark, 1 mole lit, 2 game over
  int         m_left;
  int         m_hits;
  int         m_misses;
  int         m_prev;
  int         m_mole;
  logic [15:0] m_lfsr;
  logic [7:0] m_s, m_sp;
  logic       m_hp, m_mp;
  logic [7:0] m_press;
`ifdef MOLE_SW_SYNC_EN
  logic [7:0] m_s1;
`endif

  assign m_press = m_s & ~m_sp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_left <= GT; m_hits <= 0; m_misses <= 0;
      m_prev <= 0; m_mole <= 0; m_lfsr <= 16'hACE1;
      m_s <= 8'h00; m_sp <= 8'h00; m_hp <= 1'b0; m_mp <= 1'b0;
`ifdef MOLE_SW_SYNC_EN
      m_s1 <= 8'h00;
`endif
    end else begin
      m_lfsr <= lfsr_next(m_lfsr);
      m_sp   <= m_s;
`ifdef MOLE_SW_SYNC_EN
      m_s1 <= sw;
      m_s  <= m_s1;
`else
      m_s  <= sw;
`endif
      m_hp <= 1'b0;
      m_mp <= 1'b0;
      if (!pause) begin
        if (m_phase == 0) begin
          if (m_left == 1) begin
            m_mole  <= pick_idx(m_lfsr, m_prev);
            m_prev  <= pick_idx(m_lfsr, m_prev);
            m_phase <= 1;
            m_left  <= lev ? TF : TS;
          end else begin
            m_left <= m_left - 1;
          end
        end else if (m_phase == 1) begin
          if (m_press != 0 && (m_press & ~(8'd1 << m_mole)) == 0) begin
            m_hits  <= m_hits + 1;
            m_hp    <= 1'b1;
            m_phase <= 0;
            m_left  <= GT;
          end else if (m_press != 0 || m_left == 1) begin
            m_misses <= m_misses + 1;
            m_mp     <= 1'b1;
            m_phase  <= (m_misses + 1 == MM) ? 2 : 0;
            m_left   <= GT;
          end else begin
            m_left <= m_left - 1;
          end
        end
      end
    end
  end

  function automatic logic [26:0] model_out();
    logic [7:0] l;
    l = (m_phase == 2) ? 8'hFF : (m_phase == 1) ? (8'd1 << m_mole) : 8'h00;
    return {l, to_bcd((m_hits > 99) ? 99 : m_hits), to_bcd(m_misses), m_hp, m_mp, (m_phase == 2)};
  endfunction

  // Every cycle, compare all outputs against the model.
  always begin
    @(posedge clk);
    #2;
    check("lockstep", {led, score_bcd, miss_bcd, hit_p, miss_p, game_over}, model_out());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sw = 8'h00; pause = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_lit();
    int n = 0;
    while (!(led != 8'h00 && led != 8'hFF) && n < 200) begin
      tick(); n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_lit: no mole within 200 cycles, led=0x%0h expected one-hot", led);
    end
  endtask

  typedef struct {
    logic       lev;
    int         kind;   // 0 correct press, 1 lit+extra bit, 2 no press
    int         at;     // cycles into SHOW; -1 lands on timeout cycle, -2 one cycle after
    logic       hit;
    logic       miss;
    logic       over;
    logic [7:0] score;
    logic [7:0] misses;
    int         width;  // 0 = not checked
  } vec_t;

  initial begin : watchdog
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    vec_t       vecs[5];
    int         n, w, at, bad, r;
    logic [7:0] lit;

    vecs[0] = '{1'b0, 0,  2, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 0};
    vecs[1] = '{1'b1, 0, -1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 0};
    vecs[2] = '{1'b0, 0, -2, 1'b0, 1'b1, 1'b0, 8'h02, 8'h01, TS};
    vecs[3] = '{1'b1, 1,  0, 1'b0, 1'b1, 1'b0, 8'h02, 8'h02, 0};
    vecs[4] = '{1'b1, 2,  0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h03, TF};

    // Reset release and first mole
    rst = 1'b1;
    tick(); tick();
    check("reset_outputs", {led, score_bcd, miss_bcd, hit_p, miss_p, game_over}, 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("dark_before_first_mole", led, 8'h00);
    end
    tick();
    check("first_mole_onehot", 32'($onehot(led)), 32'd1);
    lit = led; n = 0;
    while (led == lit && n < 100) begin tick(); n++; end
    check("slow_mole_width", n, TS);
    check("timeout_miss", {led, hit_p, miss_p, miss_bcd}, {8'h00, 1'b0, 1'b1, 8'h01});
    tick();
    check("miss_pulse_one_cycle", miss_p, 1'b0);

    // Correct hit
    wait_lit();
    lit = led;
    repeat (4) tick();
    sw = lit;
    repeat (LAT - 1) tick();
    check("hit_not_early", led, lit);
    tick();
    check("hit_result", {led, hit_p, miss_p, score_bcd, miss_bcd}, {8'h00, 1'b1, 1'b0, 8'h01, 8'h01});
    tick();
    check("hit_pulse_one_cycle", hit_p, 1'b0);
    sw = 8'h00;

    // Wrong press, then held switches do not re-register and the game ends
    wait_lit();
    lit = led;
    tick(); tick();
    sw = lit | {lit[5:0], lit[7:6]};
    repeat (LAT) tick();
    check("wrong_press_miss", {led, hit_p, miss_p, score_bcd, miss_bcd}, {8'h00, 1'b0, 1'b1, 8'h01, 8'h02});
    wait_lit();
    lit = led; n = 0;
    while (led == lit && n < 100) begin tick(); n++; end
    check("held_switch_width", n, TS);
    check("game_over_state", {led, game_over, miss_p, miss_bcd, score_bcd}, {8'hFF, 1'b1, 1'b1, 8'h03, 8'h01});
    for (int i = 0; i < 20; i++) begin
      sw = 8'($urandom); pause = i[2]; lev = i[0];
      tick();
    end
    pause = 1'b0;
    check("over_frozen", {led, game_over, hit_p, miss_p, miss_bcd, score_bcd}, {8'hFF, 1'b1, 1'b0, 1'b0, 8'h03, 8'h01});
    rst = 1'b1; lev = 1'b0; sw = 8'h00;
    tick();
    check("reset_clears", {led, score_bcd, miss_bcd, hit_p, miss_p, game_over}, 32'h0);
    tick();
    rst = 1'b0;

    // Pause mid-SHOW with a press during pause
    wait_lit();
    lit = led;
    repeat (5) tick();
    pause = 1'b1;
    sw = lit;
    bad = 0;
    repeat (50) begin
      tick();
      if (led !== lit || hit_p !== 1'b0 || miss_p !== 1'b0) bad++;
    end
    check("pause_hold", bad, 0);
    pause = 1'b0;
    n = 0;
    while (led == lit && n < 100) begin tick(); n++; end
    check("pause_remaining_width", n, TS - 5);
    check("pause_press_discarded", {hit_p, miss_p, score_bcd}, {1'b0, 1'b1, 8'h00});
    sw = 8'h00;

    // Vector table: level select, boundary timing, wrong press, game over
    do_reset();
    for (int i = 0; i < 5; i++) begin
      lev = vecs[i].lev;
      sw = 8'h00;
      wait_lit();
      lit = led;
      w = vecs[i].lev ? TF : TS;
      at = (vecs[i].at == -1) ? w - LAT : (vecs[i].at == -2) ? w - LAT + 1 : vecs[i].at;
      n = 0;
      if (vecs[i].kind != 2) begin
        repeat (at) begin tick(); n++; end
        sw = (vecs[i].kind == 0) ? lit : (lit | {lit[5:0], lit[7:6]});
      end
      while (led == lit && n < 100) begin tick(); n++; end
      check($sformatf("vec%0d_outcome", i),
            {led, hit_p, miss_p, game_over, score_bcd, miss_bcd},
            {(vecs[i].over ? 8'hFF : 8'h00), vecs[i].hit, vecs[i].miss, vecs[i].over,
             vecs[i].score, vecs[i].misses});
      if (vecs[i].width != 0) check($sformatf("vec%0d_width", i), n, vecs[i].width);
    end
    sw = 8'h00;

    // Saturation over 100 consecutive hits
    lev = 1'b0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      wait_lit();
      lit = led;
      sw = lit;
      repeat (LAT) tick();
      check("sat_hit", {led, hit_p, score_bcd}, {8'h00, 1'b1, to_bcd((i + 1 > 99) ? 99 : i + 1)});
      if (i == 9)  check("bcd_rollover_10", score_bcd, 8'h10);
      if (i == 99) check("score_saturated", score_bcd, 8'h99);
      sw = 8'h00;
    end

    // Randomized play checked by the lockstep model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 20 && led != 8'h00 && led != 8'hFF) sw = sw | led;
      else if (r < 30) sw = 8'($urandom);
      else if (r < 45) sw = 8'h00;
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      if ($urandom_range(0, 31) == 0) lev = ~lev;
      if ((game_over && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    pause = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_judge.md
# mole_judge

Game-side counterpart of the player: owns the eight mole LEDs, decides which mole lights and for how long, watches the eight switches for whacks, and keeps score and miss counts. Sits inside `main` between the switch inputs and the display/LED logic. Its `score_bcd` feeds the seven-segment driver and its `led` drives the board LEDs directly.

## Interface
- `TICK_SLOW`, default 100_000_000: mole visible time in cycles when `lev`=0.
- `TICK_FAST`, default 50_000_000: mole visible time in cycles when `lev`=1.
- `GAP_TICKS`, default 25_000_000: dark time in cycles between moles.
- `MAX_MISS`, default 5: miss count (1–99) that ends the game.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `pause`, in, 1: freezes the game while high.
- `lev`, in, 1: difficulty select.
- `sw`, in, 8: player switches.
- `led`, out, 8: one-hot mole, all-zero when dark, 8'hFF when the game is over.
- `score_bcd`, out, 8: hits as two BCD digits, saturating at 99.
- `miss_bcd`, out, 8: misses as two BCD digits.
- `hit_p`, out, 1: one-cycle pulse on a hit.
- `miss_p`, out, 1: one-cycle pulse on a miss.
- `game_over`, out, 1: high in state OVER.

## Operation
- **Reset values:** `led`=0, `score_bcd`=0, `miss_bcd`=0, `hit_p`=0, `miss_p`=0, `game_over`=0, state GAP, timer=`GAP_TICKS`-1, LFSR=16'hACE1, previous mole index=0, switch sample registers=0.
- **LFSR:**
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle out of reset, including while paused.
  - Candidate mole index = `lfsr[2:0]`. If it equals the previous index, use (index+1) mod 8.
- **Switch sampling:**
  - Sampled switch vector `s`.
  - `press = s & ~s_prev`, evaluated every cycle. `s_prev` updates even while paused, so a switch held through pause never registers.
- **GAP state:**
  - `led`=0. Timer decrements on each unpaused cycle.
  - At timer==0 → SHOW. `led` loads the chosen one-hot mole. Timer loads (`lev` ? `TICK_FAST` : `TICK_SLOW`)-1, with `lev` sampled only at this point.
  - Presses in GAP are ignored.
- **SHOW state**, on each unpaused cycle:
  - **Hit:** `press` nonzero and `press == (press & led)`. `score_bcd`+1 (holds at 99), `hit_p`, → GAP.
  - **Wrong press:** any `press` bit outside `led`, even if the lit bit is also pressed. Miss, → GAP.
  - **Timeout:** timer==0 with `press`==0. Miss, → GAP.
  - A hit on the same cycle as timeout counts as a hit.
  - **On entering GAP:** `led`=0, timer=`GAP_TICKS`-1.
- **Miss:** `miss_bcd`+1 and `miss_p`. If the new count equals `MAX_MISS`, go to OVER instead of GAP.
- **OVER:** `led`=8'hFF, `game_over`=1, counts frozen, all inputs ignored. Left only by `rst`.
- **Pause:**
  - Timer, state, `led`, and counts hold.
  - Presses are discarded and pulses stay 0.
- **BCD arithmetic:** ones digit 9 → 0 with tens+1. Score stops at 8'h99.
- **Reset mid-operation:** all registers return to their reset values immediately. No partial updates.

## Timing
- The first mole lights on the `GAP_TICKS`-th rising edge after `rst` falls.
- An unpressed mole stays lit exactly `TICK_*` cycles. The dark gap is exactly `GAP_TICKS` cycles, plus any paused cycles.
- Switch rise to `led` clear, count update and pulse:
  - 2 edges without `SW_SYNC_EN`.
  - 3 edges with it.
- `hit_p` and `miss_p` are registered, high for exactly one cycle, and never high together.
- All outputs are registered.

## Configuration
- `MOLE_SW_SYNC_EN`
  - **Defined:** `sw` passes through a two-flop synchronizer before `s`. Press latency grows by one cycle.
  - **Undefined:** `s` is a single register of `sw`.
- Game behaviour is otherwise identical.

## Test plan
All scenarios use `TICK_SLOW`=20, `TICK_FAST`=10, `GAP_TICKS`=4, `MAX_MISS`=3, macro undefined.

1. **Reset release and first mole:** release `rst`, no switches.
   - `led`=0 for 3 edges, then one-hot on edge 4.
   - `led` clears after 20 cycles, `miss_p` pulses once, `miss_bcd`=8'h01.
2. **Correct hit:** drive `sw`=`led` 5 cycles into SHOW.
   - `led`=0 two edges later, `hit_p` one cycle, `score_bcd`=8'h01, `miss_bcd` unchanged.
3. **Wrong switch:** mole on bit 3, press bit 3 and bit 5 together.
   - Counts as a miss: `miss_p`, `score_bcd` unchanged.
   - A held lit switch pressed at the next mole does not re-register.
4. **Pause:** pause for 50 cycles mid-SHOW.
   - `led` holds, no pulses.
   - After unpause, the mole lasts the remaining cycles, for 20 total unpaused.
   - A switch pressed during pause yields no hit.
5. **Level and game over:**
   - With `lev`=1, mole width is 10 cycles.
   - The third miss sets `led`=8'hFF, `game_over`=1 and `miss_bcd`=8'h03, all frozen.
   - `rst` clears everything.
6. **Saturation:** 100 consecutive hits.
   - `score_bcd` goes 8'h09 → 8'h10 with correct digit rollover, stops at 8'h99, and `hit_p` still pulses.
   - Repeat with the macro defined and confirm latency is 3 edges.
